phy_tx_stim_checker: RTL and testbench

- Synthesizable, parametrised stimulus generator and output checker for the PHY TX path.
- Drives data_input/valid/active into the TX datapath from a programmable pattern source.
- Compares the behavioural and structural DUT outputs lane-by-lane, counts words and mismatches, and reports pass/fail.
- Runs on clk_2f beside the TX DUT pair, replacing hand-written fixed stimulus sequences.

---
 rtl/phy_tx_stim_checker.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_phy_tx_stim_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_stim_checker.sv
// -----------------------------------------------------------------------------
// phy_tx_stim_checker
//
// Stimulus generator and lane-by-lane output checker for the PHY TX path.
// It sits on clk_2f beside a behavioural/structural TX pair. It feeds both
// of them the same data_input/valid/active stream from a programmable pattern
// source. It compares their outputs, counts words and mismatches, and reports
// pass/fail once the drain window has closed.
//
// Optional build macro:
//   STIM_FIRST_ERR_EN : when defined, the first mismatch of a run is captured
//                       (lowest mismatching lane, its ref and dut words).
//                       When undefined, first_err_* are tied to zero.
//
// Ports:
//   clk_2f          clock, all logic on the rising edge
//   reset           asynchronous active-low reset
//   start           one-cycle pulse; starts a run from IDLE or DONE
//   mode            00 incrementing, 01 Galois LFSR, 10/11 constant SEED
//   valid_rand      0: every word valid, 1: valid taken from an 8-bit LFSR
//   data_input      stimulus word (low DATA_W bits of the pattern register)
//   valid, active   stimulus qualifiers
//   ref_data/valid  behavioural outputs, lane i at [i*DATA_W +: DATA_W]
//   dut_data/valid  structural outputs, same packing
//   busy, done      run status (busy in RUN/DRAIN, done in DONE)
//   pass            meaningful only while done=1
//   tx_count        valid words generated this run
//   rx_count        ref_valid words seen this run, summed over lanes
//   err_count       lane mismatches this run, saturating
//   first_err_*     first-mismatch capture (see STIM_FIRST_ERR_EN)
// -----------------------------------------------------------------------------

// Per-lane comparator: a lane mismatches when the valids disagree, or when
// both are valid and the words differ.
module phy_tx_stim_lane_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] ref_d,
    input  logic [DATA_W-1:0] dut_d,
    input  logic              ref_v,
    input  logic              dut_v,
    output logic              mism
);
    assign mism = (ref_v != dut_v) || (ref_v && (ref_d != dut_d));
endmodule

module phy_tx_stim_checker #(
    parameter int          DATA_W    = 32,
    parameter int          LANES     = 2,
    parameter int          NUM_WORDS = 8,
    parameter int          DRAIN_CYC = 8,
    parameter logic [31:0] SEED      = 32'hFFFFEEEE
) (
    input  logic                    clk_2f,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    valid_rand,
    output logic [DATA_W-1:0]       data_input,
    output logic                    valid,
    output logic                    active,
    input  logic [LANES*DATA_W-1:0] ref_data,
    input  logic [LANES-1:0]        ref_valid,
    input  logic [LANES*DATA_W-1:0] dut_data,
    input  logic [LANES-1:0]        dut_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic [15:0]             err_count,
    output logic [7:0]              first_err_lane,
    output logic [DATA_W-1:0]       first_err_ref,
    output logic [DATA_W-1:0]       first_err_dut
);

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [7:0]  VLFSR_INIT = 8'hA5;
    localparam int          CW   = $clog2(LANES + 1);
    localparam int          DCW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [15:0]    LAST_IDX  = 16'(NUM_WORDS - 1);
    localparam logic [DCW-1:0] LAST_DRN  = DCW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state;
    logic [31:0]    pattern;
    logic [7:0]     vlfsr;
    logic [15:0]    idx;
    logic [DCW-1:0] drain_cnt;

    // ------------------------------------------------------------------
    // Pattern / valid generators
    // ------------------------------------------------------------------
    function automatic logic [31:0] pat_step(input logic [31:0] p, input logic [1:0] m);
        case (m)
            2'b00:   return p + 32'd1;
            2'b01:   return (p >> 1) ^ (p[0] ? LFSR_POLY : 32'd0);
            default: return p;                 // constant (11 behaves as 10)
        endcase
    endfunction

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
    function automatic logic [7:0] vl_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Per-lane compare
    // ------------------------------------------------------------------
    logic [LANES-1:0][DATA_W-1:0] ref_lane, dut_lane;
    logic [LANES-1:0]             lane_mism;

    assign ref_lane = ref_data;
    assign dut_lane = dut_data;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        phy_tx_stim_lane_cmp #(.DATA_W(DATA_W)) u_cmp (
            .ref_d (ref_lane[gi]),
            .dut_d (dut_lane[gi]),
            .ref_v (ref_valid[gi]),
            .dut_v (dut_valid[gi]),
            .mism  (lane_mism[gi])
        );
    end

    logic [CW-1:0] mism_sum, rx_sum;

    always_comb begin
        mism_sum = '0;
        rx_sum   = '0;
        for (int i = 0; i < LANES; i++) begin
            mism_sum = mism_sum + CW'(lane_mism[i]);
            rx_sum   = rx_sum + CW'(ref_valid[i]);
        end
    end

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic        check_en, start_take, last_word, emit;
    logic [31:0] src_pat;
    logic [7:0]  src_vl;
    logic [15:0] tx_nxt, rx_nxt, err_nxt;
    logic        pass_nxt;

    assign check_en   = (state == S_RUN) || (state == S_DRAIN);
    assign start_take = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_word  = (state == S_RUN) && (idx == LAST_IDX);
    assign emit       = start_take || ((state == S_RUN) && !last_word);

    // The start edge emits word 0 straight from SEED / the LFSR init value,
    // so the first word is on the outputs in the first RUN cycle.
    assign src_pat = (state == S_RUN) ? pattern : SEED;
    assign src_vl  = (state == S_RUN) ? vlfsr   : VLFSR_INIT;

    // tx_count follows the word currently on the outputs, so it lags
    // data_input by one cycle like the receive-side counters.
    assign tx_nxt  = ((state == S_RUN) && valid) ? sat_add(tx_count, 16'd1) : tx_count;
    assign rx_nxt  = check_en ? sat_add(rx_count, 16'(rx_sum)) : rx_count;
    assign err_nxt = check_en ? sat_add(err_count, 16'(mism_sum)) : err_count;
    // pass is judged on the post-update counts so the last drain-cycle
    // compare is included on the same edge that raises done.
    assign pass_nxt = (err_nxt == 16'd0) && (rx_nxt == tx_nxt);

    // ------------------------------------------------------------------
    // Control FSM and status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            tx_count  <= '0;
            rx_count  <= '0;
            err_count <= '0;
        end else begin
            tx_count  <= tx_nxt;
            rx_count  <= rx_nxt;
            err_count <= err_nxt;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        idx       <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        tx_count  <= '0;
                        rx_count  <= '0;
                        err_count <= '0;
                    end
                end
                S_RUN: begin
                    if (last_word) begin
                        if (DRAIN_CYC == 0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= pass_nxt;
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAST_DRN) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= pass_nxt;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus datapath: drive a word whenever one is due, zeros otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            data_input <= '0;
            valid      <= 1'b0;
            active     <= 1'b0;
            pattern    <= SEED;
            vlfsr      <= VLFSR_INIT;
        end else if (emit) begin
            data_input <= src_pat[DATA_W-1:0];
            valid      <= valid_rand ? src_vl[0] : 1'b1;
            active     <= 1'b1;
            pattern    <= pat_step(src_pat, mode);
            vlfsr      <= vl_step(src_vl);
        end else begin
            data_input <= '0;
            valid      <= 1'b0;
            active     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // First-error capture
    // ------------------------------------------------------------------
`ifdef STIM_FIRST_ERR_EN
    logic              fe_seen;
    logic [7:0]        fe_sel;
    logic [DATA_W-1:0] fe_ref_c, fe_dut_c;

    // Walk from the top lane down so the lowest mismatching lane wins.
    always_comb begin
        fe_sel   = '0;
        fe_ref_c = '0;
        fe_dut_c = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_mism[i]) begin
                fe_sel   = 8'(i);
                fe_ref_c = ref_valid[i] ? ref_lane[i] : '0;
                fe_dut_c = dut_valid[i] ? dut_lane[i] : '0;
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            fe_seen        <= 1'b0;
            first_err_lane <= '0;
            first_err_ref  <= '0;
            first_err_dut  <= '0;
        end else if (start_take) begin
            fe_seen        <= 1'b0;
            first_err_lane <= '0;
            first_err_ref  <= '0;
            first_err_dut  <= '0;
        end else if (check_en && (|lane_mism) && !fe_seen) begin
            fe_seen        <= 1'b1;
            first_err_lane <= fe_sel;
            first_err_ref  <= fe_ref_c;
            first_err_dut  <= fe_dut_c;
        end
    end
`else
    assign first_err_lane = '0;
    assign first_err_ref  = '0;
    assign first_err_dut  = '0;
`endif

endmodule

// File: tb/tb_phy_tx_stim_checker.sv
// Bench for phy_tx_stim_checker: directed table of runs, hand sequences for
// mid-run reset and ignored start/idle inputs, then randomized runs scored
// against a word/valid/lane model computed from the pattern rules.
module tb_phy_tx_stim_checker;

    localparam int          W  = 32;
    localparam int          L  = 2;
    localparam int          N  = 8;
    localparam int          D  = 8;
    localparam logic [31:0] SD = 32'hFFFFEEEE;

    logic clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    logic           reset, start, valid_rand;
    logic [1:0]     mode;
    logic [L*W-1:0] ref_data, dut_data;
    logic [L-1:0]   ref_valid, dut_valid;

    logic [W-1:0]   data_input, first_err_ref, first_err_dut;
    logic           valid, active, busy, done, pass;
    logic [15:0]    tx_count, rx_count, err_count;
    logic [7:0]     first_err_lane;

    // Second instance with SEED=1, used only for the LFSR word check.
    logic [L*W-1:0] z_data  = '0;
    logic [L-1:0]   z_valid = '0;
    logic [W-1:0]   u1_data, u1_fref, u1_fdut;
    logic           u1_valid, u1_active, u1_busy, u1_done, u1_pass;
    logic [15:0]    u1_tx, u1_rx, u1_err;
    logic [7:0]     u1_flane;

    phy_tx_stim_checker u_dut (
        .clk_2f(clk_2f), .reset(reset), .start(start), .mode(mode),
        .valid_rand(valid_rand), .data_input(data_input), .valid(valid),
        .active(active), .ref_data(ref_data), .ref_valid(ref_valid),
        .dut_data(dut_data), .dut_valid(dut_valid), .busy(busy), .done(done),
        .pass(pass), .tx_count(tx_count), .rx_count(rx_count),
        .err_count(err_count), .first_err_lane(first_err_lane),
        .first_err_ref(first_err_ref), .first_err_dut(first_err_dut)
    );

    phy_tx_stim_checker #(.SEED(32'h1)) u_dut1 (
        .clk_2f(clk_2f), .reset(reset), .start(start), .mode(mode),
        .valid_rand(valid_rand), .data_input(u1_data), .valid(u1_valid),
        .active(u1_active), .ref_data(z_data), .ref_valid(z_valid),
        .dut_data(z_data), .dut_valid(z_valid), .busy(u1_busy), .done(u1_done),
        .pass(u1_pass), .tx_count(u1_tx), .rx_count(u1_rx),
        .err_count(u1_err), .first_err_lane(u1_flane),
        .first_err_ref(u1_fref), .first_err_dut(u1_fdut)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] galois(input logic [31:0] p);
        if (p[0]) return (p >> 1) ^ 32'h80200003;
        return p >> 1;
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] m, input int k);
        logic [31:0] p;
        case (m)
            2'd0:    return SD + 32'(k);
            2'd1: begin
                p = SD;
                for (int i = 0; i < k; i++) p = galois(p);
                return p;
            end
            default: return SD;
        endcase
    endfunction

    function automatic bit model_valid(input bit vr, input int k);
        logic [7:0] q;
        if (!vr) return 1'b1;
        q = 8'hA5;
        for (int i = 0; i < k; i++) q = {q[6:0], ^(q & 8'hB8)};
        return q[0];
    endfunction

    // ---------------- directed table ----------------
    // kind: 0 loopback, 1 flip bit0 of lane1 dut word, 2 lane0 dut_valid stuck 0,
    //       3 extra matching word on lane1 in the last drain cycle, 4 random
    typedef struct {
        logic [1:0] mode;
        bit         vr;
        int         kind;
        int         pulse_at;
        int         e_tx, e_rx, e_err, e_pass;
    } vec_t;

    vec_t tbl[8];

    task automatic check_zero(input string tag);
        chk({tag, " data_input"}, data_input, 32'h0);
        chk({tag, " valid"}, 32'(valid), 32'h0);
        chk({tag, " active"}, 32'(active), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " pass"}, 32'(pass), 32'h0);
        chk({tag, " tx_count"}, 32'(tx_count), 32'h0);
        chk({tag, " rx_count"}, 32'(rx_count), 32'h0);
        chk({tag, " err_count"}, 32'(err_count), 32'h0);
        chk({tag, " first_err_lane"}, 32'(first_err_lane), 32'h0);
        chk({tag, " first_err_ref"}, first_err_ref, 32'h0);
        chk({tag, " first_err_dut"}, first_err_dut, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, output int o_tx, output int o_rx, output int o_err);
        logic [31:0]          w[N];
        bit                   vv[N];
        logic [L-1:0][W-1:0]  rd, dd;
        logic [L-1:0]         rv, dv;
        int                   ord, lane, e_tx, e_rx, e_err, r, ln;
        bit                   flipped, fe_seen, mm;
        logic [7:0]           fe_lane;
        logic [31:0]          fe_ref, fe_dut;
        logic [31:0]          lfsr1[3];
        lfsr1[0] = 32'h1; lfsr1[1] = 32'h80200003; lfsr1[2] = 32'hC0300002;
        e_tx = 0; e_rx = 0; e_err = 0; ord = 0; flipped = 0;
        fe_seen = 0; fe_lane = '0; fe_ref = '0; fe_dut = '0;
        for (int k = 0; k < N; k++) begin
            w[k]  = model_word(v.mode, k);
            vv[k] = model_valid(v.vr, k);
            if (vv[k]) e_tx++;
        end
        @(negedge clk_2f);
        mode = v.mode; valid_rand = v.vr; start = 1'b1;
        ref_valid = '0; dut_valid = '0; ref_data = '0; dut_data = '0;
        for (int c = 0; c < N + D; c++) begin
            @(negedge clk_2f);
            start = (c == v.pulse_at);
            chk($sformatf("data_input c%0d", c), data_input, (c < N) ? w[c] : 32'h0);
            chk($sformatf("valid c%0d", c), 32'(valid), (c < N) ? 32'(vv[c]) : 32'h0);
            chk($sformatf("active c%0d", c), 32'(active), (c < N) ? 32'h1 : 32'h0);
            chk($sformatf("busy c%0d", c), 32'(busy), 32'h1);
            chk($sformatf("done c%0d", c), 32'(done), 32'h0);
            if (c == 0) begin
                chk("cleared tx_count", 32'(tx_count), 32'h0);
                chk("cleared rx_count", 32'(rx_count), 32'h0);
                chk("cleared err_count", 32'(err_count), 32'h0);
                chk("cleared pass", 32'(pass), 32'h0);
            end
            if (v.mode == 2'd1 && c < 3)
                chk($sformatf("seed1 lfsr word %0d", c), u1_data, lfsr1[c]);
            // lane traffic for this cycle: each valid word goes to one lane, round robin
            rv = '0; rd = '0; lane = -1;
            if (c < N && vv[c]) begin
                lane = ord % L;
                rv[lane] = 1'b1;
                rd[lane] = w[c];
                ord++;
            end
            dv = rv; dd = rd;
            case (v.kind)
                1: if (lane == 1 && !flipped) begin dd[1][0] = ~dd[1][0]; flipped = 1; end
                2: dv[0] = 1'b0;
                3: if (c == N + D - 1) begin
                       rv[1] = 1'b1; dv[1] = 1'b1; rd[1] = 32'h1234; dd[1] = 32'h1234;
                   end
                4: begin
                       rv = L'($urandom);
                       for (int i = 0; i < L; i++) rd[i] = $urandom;
                       dv = rv; dd = rd;
                       r  = $urandom_range(0, 3);
                       ln = $urandom_range(0, L - 1);
                       if (r == 0) dv[ln] = ~dv[ln];
                       else if (r == 1) dd[ln] = dd[ln] ^ (32'h1 << $urandom_range(0, 31));
                   end
                default: ;
            endcase
            for (int i = 0; i < L; i++) begin
                mm = (rv[i] != dv[i]) || (rv[i] && dv[i] && rd[i] != dd[i]);
                if (mm) e_err++;
                if (rv[i]) e_rx++;
                if (mm && !fe_seen) begin
                    fe_seen = 1; fe_lane = 8'(i);
                    fe_ref  = rv[i] ? rd[i] : 32'h0;
                    fe_dut  = dv[i] ? dd[i] : 32'h0;
                end
            end
            ref_valid = rv; dut_valid = dv; ref_data = rd; dut_data = dd;
        end
        @(negedge clk_2f);
        start = 1'b0;
        ref_valid = '0; dut_valid = '0; ref_data = '0; dut_data = '0;
        chk("end done", 32'(done), 32'h1);
        chk("end busy", 32'(busy), 32'h0);
        chk("end active", 32'(active), 32'h0);
        chk("end tx_count", 32'(tx_count), 32'(e_tx));
        chk("end rx_count", 32'(rx_count), 32'(e_rx));
        chk("end err_count", 32'(err_count), 32'(e_err));
        chk("end pass", 32'(pass), 32'((e_err == 0) && (e_rx == e_tx)));
        if (v.e_tx >= 0) begin
            chk("table tx_count", 32'(tx_count), 32'(v.e_tx));
            chk("table rx_count", 32'(rx_count), 32'(v.e_rx));
            chk("table err_count", 32'(err_count), 32'(v.e_err));
            chk("table pass", 32'(pass), 32'(v.e_pass));
        end
`ifndef STIM_FIRST_ERR_EN
        fe_lane = '0; fe_ref = '0; fe_dut = '0;
`endif
        chk("first_err_lane", 32'(first_err_lane), 32'(fe_lane));
        chk("first_err_ref", first_err_ref, fe_ref);
        chk("first_err_dut", first_err_dut, fe_dut);
        o_tx = e_tx; o_rx = e_rx; o_err = e_err;
    endtask

    // Mismatching lane traffic while idle/done must not be counted.
    task automatic idle_noise(input int e_rx, input int e_err, input string tag);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_2f);
            ref_valid = 2'b11; dut_valid = 2'b01;
            ref_data = {$urandom, $urandom}; dut_data = {$urandom, $urandom};
        end
        @(negedge clk_2f);
        chk({tag, " rx_count"}, 32'(rx_count), 32'(e_rx));
        chk({tag, " err_count"}, 32'(err_count), 32'(e_err));
        chk({tag, " busy"}, 32'(busy), 32'h0);
        ref_valid = '0; dut_valid = '0; ref_data = '0; dut_data = '0;
    endtask

    initial begin
        int t_tx, t_rx, t_err;
        vec_t rv_vec;
        tbl[0] = '{2'd0, 1'b0, 0, -1, 8, 8, 0, 1};
        tbl[1] = '{2'd1, 1'b0, 0, -1, 8, 8, 0, 1};
        tbl[2] = '{2'd2, 1'b0, 0, -1, 8, 8, 0, 1};
        tbl[3] = '{2'd3, 1'b0, 0, -1, 8, 8, 0, 1};
        tbl[4] = '{2'd0, 1'b0, 1, -1, 8, 8, 1, 0};
        tbl[5] = '{2'd0, 1'b0, 2, -1, 8, 8, 4, 0};
        tbl[6] = '{2'd2, 1'b0, 3, -1, 8, 9, 0, 0};
        tbl[7] = '{2'd0, 1'b0, 0,  2, 8, 8, 0, 1};

        reset = 1'b0; start = 1'b0; mode = 2'd0; valid_rand = 1'b0;
        ref_valid = '0; dut_valid = '0; ref_data = '0; dut_data = '0;
        @(negedge clk_2f);
        check_zero("reset");
        reset = 1'b1;
        idle_noise(0, 0, "idle");
        chk("idle done", 32'(done), 32'h0);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], t_tx, t_rx, t_err);

        idle_noise(8, 0, "done hold");
        chk("done hold pass", 32'(pass), 32'h1);
        chk("done hold done", 32'(done), 32'h1);

        // Reset mid-run at word 3, then a full run must start over from SEED.
        @(negedge clk_2f);
        mode = 2'd0; valid_rand = 1'b0; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_2f);
            start = 1'b0;
        end
        chk("pre-reset word 3", data_input, SD + 32'd3);
        #2 reset = 1'b0;
        #1 check_zero("async reset");
        @(negedge clk_2f);
        reset = 1'b1;
        run_vec(tbl[0], t_tx, t_rx, t_err);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            rv_vec.mode     = 2'($urandom_range(0, 3));
            rv_vec.vr       = 1'($urandom_range(0, 1));
            rv_vec.kind     = 4;
            rv_vec.pulse_at = $urandom_range(0, N + D - 1);
            rv_vec.e_tx = -1; rv_vec.e_rx = -1; rv_vec.e_err = -1; rv_vec.e_pass = -1;
            run_vec(rv_vec, t_tx, t_rx, t_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
